// File: rtl/phase_ctrl.sv
// phase_ctrl: supervises the one-hot F/R/X/M/W phase sequence, handles HLT/debug halts
// Ports: clk, n_rst, phase, op_hlt, halt_req -> hlt, running, halted, err, inst_cnt, cyc_cnt
module phase_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [4:0]       phase,
   input  logic             op_hlt,
   input  logic             halt_req,
   output logic             hlt,
   output logic             running,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] cyc_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      ERROR  = 2'd3
   } state_t;

   localparam logic [4:0] PH_F = 5'b00001;
   localparam logic [4:0] PH_X = 5'b00100;
   localparam logic [4:0] PH_M = 5'b01000;
   localparam logic [4:0] PH_W = 5'b10000;
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [4:0]       prev_q, prev_d;
   logic             pend_q, pend_d;
   logic             hlt_q, hlt_d;
   logic             running_q, running_d;
   logic             halted_q, halted_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] inst_q, inst_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             legal;

   // W wraps back to F
   assign legal = (phase == {prev_q[3:0], prev_q[4]});

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      pend_d  = pend_q;
      inst_d  = inst_q;
      cyc_d   = cyc_q;
      unique case (state_q)
         IDLE: begin
            if (phase == PH_F) begin
               state_d = RUN;
               // seed the sequence checker so R is expected next
               prev_d  = PH_F;
            end else if (phase != 5'b0) begin
               state_d = ERROR;
            end
         end
         RUN: begin
            if (!(&cyc_q)) cyc_d = cyc_q + ONE;
            if (!legal) begin
               state_d = ERROR;
            end else begin
               prev_d = phase;
               if (phase == PH_W && !(&inst_q)) inst_d = inst_q + ONE;
               if ((phase == PH_X && op_hlt) || halt_req) pend_d = 1'b1;
               // hlt_q is only set on a legal M, so phase is W here
               if (hlt_q) state_d = HALTED;
            end
         end
         HALTED: begin
            if (phase != 5'b0) state_d = ERROR;
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = ERROR;
         end
      endcase
      if (state_d != RUN) pend_d = 1'b0;

      running_d = (state_d == RUN);
      halted_d  = (state_d == HALTED);
      err_d     = (state_d == ERROR);
      // request the stop on M so the generator parks after this W
      hlt_d     = (state_d == ERROR) ||
                  (state_q == RUN && state_d == RUN && phase == PH_M &&
                   (pend_q || halt_req));
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         prev_q    <= 5'b0;
         pend_q    <= 1'b0;
         hlt_q     <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         err_q     <= 1'b0;
         inst_q    <= '0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         pend_q    <= pend_d;
         hlt_q     <= hlt_d;
         running_q <= running_d;
         halted_q  <= halted_d;
         err_q     <= err_d;
         inst_q    <= inst_d;
         cyc_q     <= cyc_d;
      end
   end

   assign hlt      = hlt_q;
   assign running  = running_q;
   assign halted   = halted_q;
   assign err      = err_q;
   assign inst_cnt = inst_q;
   assign cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl: directed test of phase_ctrl (CNT_W=16 and CNT_W=4 instances)
// Ports: none
module tb_phase_ctrl;

   localparam logic [4:0] F = 5'b00001;
   localparam logic [4:0] R = 5'b00010;
   localparam logic [4:0] X = 5'b00100;
   localparam logic [4:0] M = 5'b01000;
   localparam logic [4:0] W = 5'b10000;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [4:0]  phase = 5'b0;
   logic        op_hlt = 1'b0;
   logic        halt_req = 1'b0;
   logic        hlt, running, halted, err;
   logic [15:0] inst_cnt, cyc_cnt;
   logic        hlt4, running4, halted4, err4;
   logic [3:0]  inst_cnt4, cyc_cnt4;
   int          total = 0;
   int          bad = 0;

   phase_ctrl #(.CNT_W(16)) u_dut (
      .clk(clk), .n_rst(n_rst), .phase(phase), .op_hlt(op_hlt),
      .halt_req(halt_req), .hlt(hlt), .running(running),
      .halted(halted), .err(err), .inst_cnt(inst_cnt), .cyc_cnt(cyc_cnt)
   );

   phase_ctrl #(.CNT_W(4)) u_dut4 (
      .clk(clk), .n_rst(n_rst), .phase(phase), .op_hlt(op_hlt),
      .halt_req(halt_req), .hlt(hlt4), .running(running4),
      .halted(halted4), .err(err4), .inst_cnt(inst_cnt4), .cyc_cnt(cyc_cnt4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [4:0] ph, input logic oh, input logic hr);
      phase    = ph;
      op_hlt   = oh;
      halt_req = hr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      phase    = 5'b0;
      op_hlt   = 1'b0;
      halt_req = 1'b0;
      n_rst    = 1'b0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic inst5();
      step(F, 0, 0); step(R, 0, 0); step(X, 0, 0);
      step(M, 0, 0); step(W, 0, 0);
   endtask

   task automatic outs(input string tag, input logic [3:0] exp_flags,
                       input int exp_inst, input int exp_cyc);
      chk({tag, ".flags"}, {hlt, running, halted, err}, exp_flags);
      chk({tag, ".inst"}, inst_cnt, exp_inst);
      chk({tag, ".cyc"}, cyc_cnt, exp_cyc);
   endtask

   initial begin
      // reset state
      do_reset();
      outs("rst", 4'b0000, 0, 0);

      // two normal instructions
      step(0, 0, 0); step(0, 0, 0);
      outs("idle0", 4'b0000, 0, 0);
      step(F, 0, 0);
      outs("enter", 4'b0100, 0, 0);
      step(R, 0, 0); step(X, 0, 0); step(M, 0, 0); step(W, 0, 0);
      chk("i1.inst", inst_cnt, 1);
      step(F, 0, 0); step(R, 0, 0); step(X, 0, 0); step(M, 0, 0); step(W, 0, 0);
      step(F, 0, 0);
      outs("run2", 4'b0100, 2, 10);

      // HLT opcode in X of instruction 2
      do_reset();
      step(0, 0, 0);
      inst5();
      step(F, 0, 0); step(R, 0, 0);
      step(X, 1, 0);
      outs("hltX", 4'b0100, 1, 7);
      step(M, 0, 0);
      outs("hltM", 4'b1100, 1, 8);
      step(W, 0, 0);
      outs("hltW", 4'b0010, 2, 9);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      outs("hold", 4'b0010, 2, 9);

      // op_hlt outside X is ignored
      do_reset();
      step(F, 1, 0); step(R, 1, 0); step(X, 0, 0); step(M, 1, 0); step(W, 1, 0);
      step(F, 0, 0); step(R, 0, 0); step(X, 0, 0); step(M, 0, 0);
      outs("ophlt_ign", 4'b0100, 1, 8);

      // halt_req pulse during R of instruction 3
      do_reset();
      inst5(); inst5();
      step(F, 0, 0);
      step(R, 0, 1);
      step(X, 0, 0);
      step(M, 0, 0);
      chk("hreq.hltM", hlt, 1);
      step(W, 0, 0);
      outs("hreq", 4'b0010, 3, 14);

      // halt_req first seen in W halts after the next instruction
      do_reset();
      step(F, 0, 0); step(R, 0, 0); step(X, 0, 0); step(M, 0, 0);
      step(W, 0, 1);
      chk("late.noh", hlt, 0);
      step(F, 0, 0); step(R, 0, 0); step(X, 0, 0); step(M, 0, 0);
      chk("late.hltM", hlt, 1);
      step(W, 0, 0);
      outs("late", 4'b0010, 2, 9);
      step(F, 0, 0);
      outs("halt2err", 4'b1001, 2, 9);

      // skipped X phase
      do_reset();
      inst5();
      step(F, 0, 0); step(R, 0, 0);
      step(M, 0, 0);
      outs("skip", 4'b1001, 1, 7);
      step(0, 0, 0); step(F, 0, 0); step(0, 0, 0);
      outs("skiphold", 4'b1001, 1, 7);

      // error wins over a simultaneous halt request
      do_reset();
      step(F, 0, 0); step(R, 0, 0); step(X, 1, 0);
      step(W, 0, 1);
      outs("prio", 4'b1001, 0, 3);

      // illegal phase straight out of IDLE
      do_reset();
      step(R, 0, 0);
      outs("idleerr", 4'b1001, 0, 0);

      // saturation, 17 instructions
      do_reset();
      for (int i = 0; i < 17; i++) inst5();
      chk("sat4.inst", inst_cnt4, 15);
      chk("sat4.cyc", cyc_cnt4, 15);
      chk("sat16.inst", inst_cnt, 17);
      chk("sat16.cyc", cyc_cnt, 84);

      // reset during the hlt-high W cycle
      do_reset();
      step(F, 0, 0); step(R, 0, 0); step(X, 1, 0); step(M, 0, 0);
      chk("mid.hlt", hlt, 1);
      phase  = W;
      n_rst  = 1'b0;
      #1;
      outs("mid.rst", 4'b0000, 0, 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      step(0, 0, 0);
      outs("mid.idle", 4'b0000, 0, 0);
      inst5();
      outs("mid.rerun", 4'b0100, 1, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction and run-cycle counters.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 phase  input  5  one-hot CPU phase from the phase generator; bit0=F, bit1=R, bit2=X, bit3=M, bit4=W; 0 = stopped.
REQ-005 op_hlt  input  1  decoded HLT opcode; meaningful only while phase==X.
REQ-006 halt_req  input  1  external debug halt request, level, synchronous to clk.
REQ-007 hlt  output  1  synchronous stop request to the phase generator; a phase generator sampling hlt=1 forces phase to 0 at that edge.
REQ-008 running  output  1  high while in state RUN.
REQ-009 halted  output  1  high while in state HALTED.
REQ-010 err  output  1  high while in state ERROR.
REQ-011 inst_cnt  output  CNT_W  count of retired instructions (completed W phases).
REQ-012 cyc_cnt  output  CNT_W  count of clock cycles spent in RUN.

Function
REQ-013 FSM states: IDLE, RUN, HALTED, ERROR; all outputs registered.
REQ-014 IDLE: phase==5'b00001 -> RUN; phase==0 -> stay; any other value -> ERROR.
REQ-015 RUN: register prev_phase each edge; legal next phase = prev_phase rotated left by one (W->F wrap).
REQ-016 RUN: phase != legal next phase (including 0, multi-hot, skipped phase) while hlt==0 -> ERROR at that edge.
REQ-017 Halt pending flag: set at any RUN edge where (phase==X and op_hlt==1) or halt_req==1; cleared on leaving RUN.
REQ-018 hlt set at the RUN edge where phase==M and (pending==1 or halt_req==1), so hlt is high exactly during the following W cycle.
REQ-019 RUN with hlt==1 and phase==W: at the next edge state -> HALTED, hlt -> 0; phase==0 is then the only legal value.
REQ-020 op_hlt outside phase X is ignored.
REQ-021 halt_req first sampled in the W cycle (after the M-edge) halts at the end of the next instruction's W.
REQ-022 HALTED: terminal until reset; any nonzero phase -> ERROR.
REQ-023 ERROR: terminal until reset; hlt held at 1 continuously to force phase to 0; err=1.
REQ-024 inst_cnt increments by 1 at every RUN edge where phase==W and the transition is legal, including the halting W; saturates at all-ones.
REQ-025 cyc_cnt increments by 1 at every edge where state==RUN at the edge; saturates at all-ones; freezes outside RUN.
REQ-026 Simultaneous halt request and illegal phase at the same edge: ERROR takes priority.
REQ-027 Counters, pending and prev_phase never change in IDLE, HALTED or ERROR.

Reset
REQ-028 n_rst==0 asynchronously forces state IDLE, hlt=0, running=0, halted=0, err=0, inst_cnt=0, cyc_cnt=0, pending=0, prev_phase=0.
REQ-029 Reset asserted mid-instruction or mid-halt discards all pending halt and error state; no hlt glitch on reset deassertion.
REQ-030 After n_rst rises the block remains IDLE until phase==F is seen; no timeout on IDLE.

Verification
REQ-031 Reset, drive phase 0,0,F,R,X,M,W,F,R,X,M,W,F -> running=1 from the edge after first F; inst_cnt=2, err=0.
REQ-032 Second instruction with op_hlt=1 during X -> hlt=1 exactly in that instruction's W cycle; next cycle halted=1, hlt=0, inst_cnt=2; phase held 0 -> state stays HALTED.
REQ-033 halt_req pulsed for one cycle during R of instruction 3 -> hlt high in instruction 3 W; halted=1, inst_cnt=3.
REQ-034 In RUN drive F,R,M (skip X) -> err=1, hlt=1 held, running=0, counters frozen at their values at the error edge.
REQ-035 CNT_W=4, run 17 instructions -> inst_cnt saturates at 15; cyc_cnt saturates at 15.
REQ-036 Assert n_rst=0 during hlt-high W cycle -> all outputs 0 immediately, state IDLE; new F after release -> RUN, inst_cnt restarts from 0.
